// File: rtl/fpu_pkg.sv
// Shared definitions for the fpu normalise/round/pack stage.
package fpu_pkg;

    localparam int EXP_WIDTH  = 8;
    localparam int FRAC_WIDTH = 23;
    localparam int BIAS       = 127;
    localparam int EXP_MAX    = 255;

    // Extended mantissa layout: {carry, hidden, fraction, G, R, S}
    localparam int MANT_WIDTH = FRAC_WIDTH + 5;
    localparam int CARRY      = FRAC_WIDTH + 4;
    localparam int HIDDEN     = FRAC_WIDTH + 3;
    localparam int G          = 2;
    localparam int R          = 1;
    localparam int S          = 0;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        ROUND,
        DONE
    } state_t;

endpackage

// File: rtl/fpu_round_ne.sv
// Round-to-nearest-even on a normalised significand with guard/round/sticky bits.
module fpu_round_ne
    import fpu_pkg::*;
#(
    parameter int FRAC_WIDTH = fpu_pkg::FRAC_WIDTH
) (
    input  logic                  hidden,
    input  logic [FRAC_WIDTH-1:0] frac,
    input  logic                  g,
    input  logic                  r,
    input  logic                  s,
    output logic [FRAC_WIDTH-1:0] frac_out,
    output logic                  carry_out,
    output logic                  inexact
);

    logic up;

    // Only a normalised significand (hidden set) is ever rounded upward.
    assign up = hidden & g & (r | s | frac[0]);

    // Carry-out of the fraction means the significand rolled over to 2.0.
    assign {carry_out, frac_out} = {1'b0, frac} + {{FRAC_WIDTH{1'b0}}, up};

    assign inexact = g | r | s;

endmodule

// File: rtl/fpu_normalize_round.sv
// Iterative normalise / round / pack stage following the fpu add/sub datapath.
// One left shift per NORM cycle; valid/ready handshake on input and output.
module fpu_normalize_round
    import fpu_pkg::*;
#(
    parameter int EXP_WIDTH  = fpu_pkg::EXP_WIDTH,
    parameter int FRAC_WIDTH = fpu_pkg::FRAC_WIDTH
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              in_sign,
    input  logic signed [EXP_WIDTH+1:0]       in_exponent,
    input  logic [FRAC_WIDTH+4:0]             in_mantissa,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [EXP_WIDTH+FRAC_WIDTH:0]     result,
    output logic                              overflow,
    output logic                              underflow,
    output logic                              inexact
);

    localparam int MW     = FRAC_WIDTH + 5;
    localparam int TOP    = MW - 1;
    localparam int HID    = MW - 2;
    // One headroom bit beyond the input width so exp+1 from 511 cannot wrap.
    localparam int IW     = EXP_WIDTH + 3;

    localparam logic signed [IW-1:0] EXP_ZERO = '0;
    localparam logic signed [IW-1:0] EXP_ONE  = IW'(1);
    localparam logic signed [IW-1:0] EXP_TOP  = IW'((1 << EXP_WIDTH) - 1);

    localparam logic [EXP_WIDTH+FRAC_WIDTH-1:0] MAG_ZERO = '0;
    localparam logic [EXP_WIDTH-1:0]            EXP_ONES = '1;
    localparam logic [FRAC_WIDTH-1:0]           FRAC_ZERO = '0;

    state_t                  state;
    logic                    sign_q;
    logic signed [IW-1:0]    exp_q;
    logic [MW-1:0]           mant_q;

    logic signed [IW-1:0]    in_exp_ext;
    logic signed [IW-1:0]    exp_rnd;
    logic [FRAC_WIDTH-1:0]   rnd_frac;
    logic                    rnd_carry;
    logic                    rnd_inexact;

    assign in_exp_ext = {in_exponent[EXP_WIDTH+1], in_exponent};
    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);

    fpu_round_ne #(
        .FRAC_WIDTH (FRAC_WIDTH)
    ) u_round (
        .hidden    (mant_q[HID]),
        .frac      (mant_q[HID-1:3]),
        .g         (mant_q[G]),
        .r         (mant_q[R]),
        .s         (mant_q[S]),
        .frac_out  (rnd_frac),
        .carry_out (rnd_carry),
        .inexact   (rnd_inexact)
    );

    assign exp_rnd = exp_q + (rnd_carry ? EXP_ONE : EXP_ZERO);

    // Control FSM with the normalising shifter and registered result/flags.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            result    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            inexact   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_q <= in_sign;
                        exp_q  <= in_exp_ext;
                        mant_q <= in_mantissa;
                        if (in_mantissa == '0) begin
                            result    <= {in_sign, MAG_ZERO};
                            overflow  <= 1'b0;
                            underflow <= 1'b0;
                            inexact   <= 1'b0;
                            state     <= DONE;
                        end else if (in_exp_ext <= EXP_ZERO) begin
                            result    <= {in_sign, MAG_ZERO};
                            overflow  <= 1'b0;
                            underflow <= 1'b1;
                            inexact   <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= NORM;
                        end
                    end
                end
                NORM: begin
                    if (mant_q[TOP]) begin
                        // Right shift keeps the dropped bit alive in sticky.
                        mant_q <= {1'b0, mant_q[TOP:2], mant_q[R] | mant_q[S]};
                        exp_q  <= exp_q + EXP_ONE;
                        state  <= ROUND;
                    end else if (mant_q[HID]) begin
                        state <= ROUND;
                    end else if (exp_q > EXP_ONE) begin
                        mant_q <= {mant_q[TOP-1:0], 1'b0};
                        exp_q  <= exp_q - EXP_ONE;
                    end else begin
                        result    <= {sign_q, MAG_ZERO};
                        overflow  <= 1'b0;
                        underflow <= 1'b1;
                        inexact   <= 1'b1;
                        state     <= DONE;
                    end
                end
                ROUND: begin
                    if (exp_rnd >= EXP_TOP) begin
                        result    <= {sign_q, EXP_ONES, FRAC_ZERO};
                        overflow  <= 1'b1;
                        underflow <= 1'b0;
                        inexact   <= 1'b1;
                    end else begin
                        result    <= {sign_q, exp_rnd[EXP_WIDTH-1:0], rnd_frac};
                        overflow  <= 1'b0;
                        underflow <= 1'b0;
                        inexact   <= rnd_inexact;
                    end
                    state <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_normalize_round.sv
// Randomised self-checking bench for fpu_normalize_round against a value-level model.
module tb_fpu_normalize_round;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [9:0]  in_exponent;
    logic [27:0] in_mantissa;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;
    logic        inexact;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] res;
        logic        ov;
        logic        un;
        logic        inx;
        int          lat;
    } expect_t;

    fpu_normalize_round dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sign     (in_sign),
        .in_exponent (in_exponent),
        .in_mantissa (in_mantissa),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .overflow    (overflow),
        .underflow   (underflow),
        .inexact     (inexact)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, want);
        end
    endtask

    // Value-level model: locate the leading one, align, round to nearest even, pack.
    function automatic expect_t model(input bit sign, input int e, input logic [27:0] m);
        expect_t x;
        int      msb;
        int      lz;
        bit      g, r, s, up;
        int      sig;
        logic [22:0] frac;
        x.ov = 0; x.un = 0; x.inx = 0;
        x.res = {sign, 31'b0};
        if (m == 0) begin
            x.lat = 1;
            return x;
        end
        if (e <= 0) begin
            x.un = 1; x.inx = 1; x.lat = 1;
            return x;
        end
        if (m[27]) begin
            m = {1'b0, m[27:2], m[1] | m[0]};
            e = e + 1;
            x.lat = 3;
        end else begin
            msb = 0;
            for (int i = 0; i < 27; i++) if (m[i]) msb = i;
            lz = 26 - msb;
            if (lz > e - 1) begin
                x.un = 1; x.inx = 1; x.lat = e + 1;
                return x;
            end
            m = m << lz;
            e = e - lz;
            x.lat = 3 + lz;
        end
        g = m[2]; r = m[1]; s = m[0];
        up = g & (r | s | m[3]);
        sig = int'(m[26:3]) + int'(up);
        if (sig >= (1 << 24)) begin
            e = e + 1;
            frac = '0;
        end else begin
            frac = sig[22:0];
        end
        if (e >= 255) begin
            x.res = {sign, 8'hFF, 23'h0};
            x.ov = 1; x.inx = 1;
        end else begin
            x.res = {sign, e[7:0], frac};
            x.inx = g | r | s;
        end
        return x;
    endfunction

    // One full transaction: accept, wait for the result, stall, release.
    task automatic run_op(input bit sign, input int e, input logic [27:0] m,
                          input int stall, input bit junk, output logic [31:0] got);
        expect_t x;
        int      cycles;
        x = model(sign, e, m);
        cycles = 0;
        while (!in_ready && cycles < 100) begin
            @(posedge clock); #1; cycles++;
        end
        chk("in_ready_before_accept", 32'(in_ready), 32'd1);
        in_sign     = sign;
        in_exponent = e[9:0];
        in_mantissa = m;
        in_valid    = 1'b1;
        @(posedge clock); #1;
        // Busy-time input activity must be ignored.
        in_valid    = junk;
        in_sign     = $urandom_range(0, 1);
        in_exponent = 10'($urandom);
        in_mantissa = 28'($urandom);
        cycles = 1;
        while (!out_valid && cycles < 200) begin
            @(posedge clock); #1; cycles++;
        end
        in_valid = 1'b0;
        chk("out_valid_seen", 32'(out_valid), 32'd1);
        chk("latency", 32'(cycles), 32'(x.lat));
        chk("result", result, x.res);
        chk("flags", {29'd0, overflow, underflow, inexact}, {29'd0, x.ov, x.un, x.inx});
        got = result;
        for (int i = 0; i < stall; i++) begin
            @(posedge clock); #1;
            chk("hold_result", result, x.res);
            chk("hold_busy", {30'd0, out_valid, in_ready}, 32'b10);
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        chk("release", {30'd0, out_valid, in_ready}, 32'b01);
    endtask

    logic [31:0] got;
    logic [27:0] m;
    int          e;

    initial begin
        reset       = 1'b0;
        in_valid    = 1'b0;
        in_sign     = 1'b0;
        in_exponent = '0;
        in_mantissa = '0;
        out_ready   = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_state", {result, 4'b0} >> 4, 32'd0);
        chk("reset_ctrl", {27'd0, in_ready, out_valid, overflow, underflow, inexact}, 32'b10000);
        reset = 1'b1;
        @(posedge clock); #1;

        // Directed cases
        run_op(1, 126, {1'b1, 1'b0, 23'h7FFFFE, 3'b000}, 0, 0, got);
        chk("dir_carry", got, 32'hBFBFFFFF);
        run_op(0, 127, {1'b0, 1'b1, 23'h0, 3'b000}, 0, 1, got);
        chk("dir_one", got, 32'h3F800000);
        run_op(0, 127, 28'h0800000, 0, 0, got);
        chk("dir_shift3", got, 32'h3E000000);
        run_op(0, 127, {1'b0, 1'b1, 23'h000001, 3'b100}, 0, 0, got);
        chk("dir_rne_up", got, 32'h3F800002);
        chk("dir_rne_up_inx", 32'(inexact), 32'd1);
        run_op(0, 127, {1'b0, 1'b1, 23'h000000, 3'b100}, 0, 0, got);
        chk("dir_rne_tie_even", got, 32'h3F800000);
        run_op(0, 127, {1'b0, 1'b1, 23'h7FFFFF, 3'b110}, 0, 0, got);
        chk("dir_rne_carry", got, 32'h40000000);
        run_op(0, 254, {1'b1, 1'b0, 23'h0, 3'b000}, 0, 0, got);
        chk("dir_overflow", got, 32'h7F800000);
        run_op(1, 40, 28'h0, 0, 0, got);
        chk("dir_neg_zero", got, 32'h80000000);
        run_op(0, 511, {1'b1, 27'h0}, 0, 0, got);
        chk("dir_exp511_carry", got, 32'h7F800000);
        run_op(1, 0, {1'b0, 1'b1, 26'h0}, 0, 0, got);
        chk("dir_exp0_flush", got, 32'h80000000);
        run_op(0, 3, 28'h0000100, 0, 0, got);
        chk("dir_norm_flush", got, 32'h00000000);
        run_op(0, 100, {1'b0, 1'b1, 23'h123456, 3'b011}, 5, 1, got);

        // Reset in the middle of a long normalisation
        in_sign = 1'b0; in_exponent = 10'd100; in_mantissa = 28'h1;
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        chk("reset_mid_norm", {29'd0, out_valid, in_ready, |result}, 32'b010);
        chk("reset_mid_flags", {29'd0, overflow, underflow, inexact}, 32'd0);

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            m = 28'($urandom) >> $urandom_range(0, 28);
            if ($urandom_range(0, 7) == 0) m = {1'b1, 27'($urandom)};
            case ($urandom_range(0, 3))
                0: e = int'($urandom_range(0, 1023)) - 512;
                1: e = int'($urandom_range(240, 260));
                2: e = int'($urandom_range(1, 30));
                default: e = int'($urandom_range(1, 254));
            endcase
            run_op($urandom_range(0, 1), e, m, $urandom_range(0, 2), $urandom_range(0, 1), got);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
